gat_bram_load_bridge: RTL and testbench



---
 rtl/gat_bram_load_bridge.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_gat_bram_load_bridge.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gat_bram_load_bridge.sv
// ---------------------------------------------------------------------------
// gat_bram_load_bridge
//
// Host-to-BRAM load bridge sitting between the PS register bank / AXI BRAM
// controller and the GAT accelerator core.
//   * Host writes are byte addressed. Each write is turned into a word
//     address and routed to one of NUM_CH load-channel BRAMs. The write data
//     is truncated to the channel width.
//   * Accepted words are counted per channel against host-programmed
//     lengths. This produces the per-channel and global load-done flags that
//     the core waits on.
//   * A pipelined, registered read-back port serves the new-feature BRAM.
//
// Optional feature (compile-time macro GAT_LOAD_CHECKSUM_EN):
//   When defined, each channel keeps a 32-bit additive checksum of its
//   accepted s_din words. The checksum is cleared on load_start.
//   state_dbg[23:0] then shows the checksum of the channel selected by s_ch.
//   When undefined, no checksum logic is built and state_dbg[23:0] shows the
//   total of accepted words.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   load_start       pulse: latch cfg_len, clear counters/flags, enter LOAD
//   load_clr         pulse: back to IDLE, clear done/error flags
//   cfg_len          per-channel expected word count, channel k at
//                    [k*CH_ADDR_W +: CH_ADDR_W]
//   s_ena/s_wea      host write enable / strobe
//   s_ch             target channel
//   s_addra          host byte address
//   s_din            host write data
//   ch_ena/ch_wea    one-hot per-channel BRAM enable / write enable
//   ch_addra/ch_din  shared word address / truncated data
//   ch_done          sticky per-channel done
//   all_done         every channel done, asserted only in READY
//   err_flags        sticky {range, overflow, misalign}
//   state_dbg        {state[1:0], zero pad, word total or checksum [23:0]}
//   feat_rd_en       feature read request
//   feat_addrb       feature byte address
//   feat_bram_addrb  registered word address to the feature BRAM
//   feat_bram_dout   feature BRAM read data (one-cycle BRAM latency)
//   feat_dout        read data, qualified by feat_valid
//   feat_valid       read data valid, two cycles after feat_rd_en
// ---------------------------------------------------------------------------
module gat_bram_load_bridge #(
  parameter int TOP_WIDTH   = 32,
  parameter int NUM_CH      = 3,
  parameter int CH_ADDR_W   = 18,
  parameter int CH_DATA_W   = 17,
  parameter int FEAT_ADDR_W = 16,
  parameter int FEAT_DATA_W = 32,
  parameter int CH_SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_start,
  input  logic                        load_clr,
  input  logic [NUM_CH*CH_ADDR_W-1:0] cfg_len,
  input  logic                        s_ena,
  input  logic                        s_wea,
  input  logic [CH_SEL_W-1:0]         s_ch,
  input  logic [CH_ADDR_W+1:0]        s_addra,
  input  logic [TOP_WIDTH-1:0]        s_din,
  output logic [NUM_CH-1:0]           ch_ena,
  output logic [NUM_CH-1:0]           ch_wea,
  output logic [CH_ADDR_W-1:0]        ch_addra,
  output logic [CH_DATA_W-1:0]        ch_din,
  output logic [NUM_CH-1:0]           ch_done,
  output logic                        all_done,
  output logic [2:0]                  err_flags,
  output logic [TOP_WIDTH-1:0]        state_dbg,
  input  logic                        feat_rd_en,
  input  logic [FEAT_ADDR_W+1:0]      feat_addrb,
  output logic [FEAT_ADDR_W-1:0]      feat_bram_addrb,
  input  logic [FEAT_DATA_W-1:0]      feat_bram_dout,
  output logic [FEAT_DATA_W-1:0]      feat_dout,
  output logic                        feat_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  localparam int DBG_W = 24;
  localparam int PAD_W = TOP_WIDTH - 2 - DBG_W;

  // The channel count is widened by one bit so that every s_ch value can be
  // range checked, including a power-of-two NUM_CH.
  localparam logic [CH_SEL_W:0] NUM_CH_L = (CH_SEL_W+1)'(NUM_CH);

  // -------------------------------------------------------------------------
  // State and shared registers
  // -------------------------------------------------------------------------
  logic [1:0]           state_reg, state_next;
  logic [2:0]           err_reg;
  logic [DBG_W-1:0]     total_reg;
  logic [NUM_CH-1:0]    ena_reg;
  logic [CH_ADDR_W-1:0] addra_reg;
  logic [CH_DATA_W-1:0] din_reg;

  // Per-channel state, collected from the generate blocks below.
  logic [NUM_CH-1:0]    done_vec;
  logic [CH_ADDR_W-1:0] len_vec [NUM_CH];

  // -------------------------------------------------------------------------
  // Write qualification
  // -------------------------------------------------------------------------
  logic                 wr_req;
  logic                 wr_check;
  logic                 ch_ok;
  logic [CH_SEL_W:0]    s_ch_ext;
  logic [CH_ADDR_W-1:0] waddr;
  logic [CH_ADDR_W-1:0] sel_len;
  logic                 sel_done;
  logic                 bad_misalign;
  logic                 bad_overflow;
  logic                 bad_range;
  logic                 accept;
  logic [NUM_CH-1:0]    wr_onehot;

  assign wr_req   = s_ena & s_wea;
  assign s_ch_ext = {1'b0, s_ch};
  assign ch_ok    = (s_ch_ext < NUM_CH_L);
  assign waddr    = s_addra[CH_ADDR_W+1:2];

  // A write that arrives together with load_start or load_clr is dropped
  // silently. The control pulse redefines the load, so the write would
  // count against a stale configuration.
  assign wr_check = (state_reg == S_LOAD) & wr_req & ~load_start & ~load_clr;

  always_comb begin
    sel_len  = '0;
    sel_done = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (s_ch_ext == (CH_SEL_W+1)'(k)) begin
        sel_len  = len_vec[k];
        sel_done = done_vec[k];
      end
    end
  end

  // Each error cause is evaluated on its own, so one bad write can raise
  // several sticky flags at once.
  assign bad_misalign = (s_addra[1:0] != 2'b00);
  assign bad_overflow = ch_ok & sel_done;
  assign bad_range    = ~ch_ok | (waddr >= sel_len);
  assign accept       = wr_check & ~bad_misalign & ~bad_overflow & ~bad_range;

  // -------------------------------------------------------------------------
  // Per-channel length, word counter and done flag
  // -------------------------------------------------------------------------
`ifdef GAT_LOAD_CHECKSUM_EN
  logic [31:0] csum_vec [NUM_CH];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CH_ADDR_W-1:0] len_reg;
      logic [CH_ADDR_W-1:0] cnt_reg;
      logic [CH_ADDR_W-1:0] cnt_next;
      logic [CH_ADDR_W-1:0] cfg_slice;
      logic                 done_reg;

      assign wr_onehot[gi] = accept & (s_ch_ext == (CH_SEL_W+1)'(gi));
      assign cfg_slice     = cfg_len[gi*CH_ADDR_W +: CH_ADDR_W];
      assign cnt_next      = cnt_reg + CH_ADDR_W'(1);

      // done_reg is set on the same edge that registers the final write.
      // It therefore rises together with that write on ch_wea.
      // A zero-length channel is done as soon as the load starts.
      always_ff @(posedge clk) begin
        if (rst) begin
          len_reg  <= '0;
          cnt_reg  <= '0;
          done_reg <= 1'b0;
        end else if (load_start) begin
          len_reg  <= cfg_slice;
          cnt_reg  <= '0;
          done_reg <= (cfg_slice == '0);
        end else if (load_clr) begin
          done_reg <= 1'b0;
        end else if (wr_onehot[gi]) begin
          cnt_reg <= cnt_next;
          if (cnt_next == len_reg) begin
            done_reg <= 1'b1;
          end
        end
      end

      assign done_vec[gi] = done_reg;
      assign len_vec[gi]  = len_reg;

`ifdef GAT_LOAD_CHECKSUM_EN
      logic [31:0] csum_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          csum_reg <= '0;
        end else if (load_start) begin
          csum_reg <= '0;
        end else if (wr_onehot[gi]) begin
          csum_reg <= csum_reg + 32'(s_din);
        end
      end

      assign csum_vec[gi] = csum_reg;
`endif
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Global FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (load_start) begin
      state_next = S_LOAD;
    end else if (load_clr) begin
      state_next = S_IDLE;
    end else if ((state_reg == S_LOAD) && (&done_vec)) begin
      state_next = S_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky error flags and accepted-word total
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= '0;
    end else if (load_start || load_clr) begin
      err_reg <= '0;
    end else if (wr_check) begin
      err_reg <= err_reg | {bad_range, bad_overflow, bad_misalign};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      total_reg <= '0;
    end else if (load_start) begin
      total_reg <= '0;
    end else if (accept) begin
      total_reg <= total_reg + DBG_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Registered BRAM write port
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ena_reg   <= '0;
      addra_reg <= '0;
      din_reg   <= '0;
    end else begin
      ena_reg <= wr_onehot;
      if (accept) begin
        addra_reg <= waddr;
        din_reg   <= s_din[CH_DATA_W-1:0];
      end
    end
  end

  assign ch_ena    = ena_reg;
  assign ch_wea    = ena_reg;
  assign ch_addra  = addra_reg;
  assign ch_din    = din_reg;
  assign ch_done   = done_vec;
  assign all_done  = (state_reg == S_READY) & (&done_vec);
  assign err_flags = err_reg;

  // -------------------------------------------------------------------------
  // Debug word
  // -------------------------------------------------------------------------
  logic [DBG_W-1:0] dbg_low;

  always_comb begin
`ifdef GAT_LOAD_CHECKSUM_EN
    dbg_low = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (s_ch_ext == (CH_SEL_W+1)'(k)) begin
        dbg_low = csum_vec[k][DBG_W-1:0];
      end
    end
`else
    dbg_low = total_reg;
`endif
  end

  assign state_dbg = {state_reg, {PAD_W{1'b0}}, dbg_low};

  // -------------------------------------------------------------------------
  // Feature read-back pipeline
  // -------------------------------------------------------------------------
  // Stage 1 registers the word address toward the BRAM. Stage 2 is the
  // BRAM's own registered read. The valid bit travels through two flops to
  // line up with that read, so data returns two cycles after the request at
  // full rate. The BRAM output is zeroed outside valid cycles.
  logic [FEAT_ADDR_W-1:0] feat_addr_reg;
  logic                   rd_v1_reg;
  logic                   rd_v2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      feat_addr_reg <= '0;
      rd_v1_reg     <= 1'b0;
      rd_v2_reg     <= 1'b0;
    end else begin
      feat_addr_reg <= feat_addrb[FEAT_ADDR_W+1:2];
      rd_v1_reg     <= feat_rd_en;
      rd_v2_reg     <= rd_v1_reg;
    end
  end

  assign feat_bram_addrb = feat_addr_reg;
  assign feat_valid      = rd_v2_reg;
  assign feat_dout       = rd_v2_reg ? feat_bram_dout : '0;

  // Byte-lane bits of the feature address and the high bits of s_din are
  // not used by the datapath.
  logic unused_bits;
  assign unused_bits = ^{s_din, feat_addrb[1:0]};

endmodule

// File: tb/tb_gat_bram_load_bridge.sv
`timescale 1ns/1ps
module tb_gat_bram_load_bridge;

  localparam int NUM_CH = 3;
  localparam int AW     = 18;
  localparam int DW     = 17;
  localparam int FAW    = 16;
  localparam int FDW    = 32;
  localparam int TW     = 32;
  localparam int SW     = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_start, load_clr;
  logic [NUM_CH*AW-1:0] cfg_len;
  logic              s_ena, s_wea;
  logic [SW-1:0]     s_ch;
  logic [AW+1:0]     s_addra;
  logic [TW-1:0]     s_din;
  logic [NUM_CH-1:0] ch_ena, ch_wea, ch_done;
  logic [AW-1:0]     ch_addra;
  logic [DW-1:0]     ch_din;
  logic              all_done;
  logic [2:0]        err_flags;
  logic [TW-1:0]     state_dbg;
  logic              feat_rd_en;
  logic [FAW+1:0]    feat_addrb;
  logic [FAW-1:0]    feat_bram_addrb;
  logic [FDW-1:0]    feat_bram_dout;
  logic [FDW-1:0]    feat_dout;
  logic              feat_valid;

  always #5 clk = ~clk;

  gat_bram_load_bridge #(
    .TOP_WIDTH(TW), .NUM_CH(NUM_CH), .CH_ADDR_W(AW), .CH_DATA_W(DW),
    .FEAT_ADDR_W(FAW), .FEAT_DATA_W(FDW)
  ) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_clr(load_clr),
    .cfg_len(cfg_len), .s_ena(s_ena), .s_wea(s_wea), .s_ch(s_ch),
    .s_addra(s_addra), .s_din(s_din), .ch_ena(ch_ena), .ch_wea(ch_wea),
    .ch_addra(ch_addra), .ch_din(ch_din), .ch_done(ch_done),
    .all_done(all_done), .err_flags(err_flags), .state_dbg(state_dbg),
    .feat_rd_en(feat_rd_en), .feat_addrb(feat_addrb),
    .feat_bram_addrb(feat_bram_addrb), .feat_bram_dout(feat_bram_dout),
    .feat_dout(feat_dout), .feat_valid(feat_valid)
  );

  // Feature BRAM: content is a fixed function of the word address, read
  // with one cycle of latency.
  function automatic logic [31:0] feat_word(logic [FAW-1:0] a);
    return {a ^ 16'hA5C3, ~a};
  endfunction

  always_ff @(posedge clk) feat_bram_dout <= feat_word(feat_bram_addrb);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard queues
  typedef struct packed {
    logic [NUM_CH-1:0] en;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     din;
  } wexp_t;
  typedef struct {
    int          at;
    logic [31:0] data;
  } rexp_t;
  wexp_t wq[$];
  rexp_t fq[$];

  // Reference model: mode 0 = idle, 1 = loading, 2 = ready
  int          m_mode;
  int          m_len [NUM_CH];
  int          m_cnt [NUM_CH];
  bit          m_done[NUM_CH];
  logic [2:0]  m_err;
  int          m_total;
  logic [31:0] m_csum[NUM_CH];

  function automatic logic [NUM_CH-1:0] m_done_vec();
    logic [NUM_CH-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[k] = m_done[k];
    return v;
  endfunction

  // One clock: update the model from the inputs now applied, let the DUT
  // take the edge, then compare the status outputs on the falling edge.
  task automatic step();
    bit acc;
    bit all_pre;
    acc = 0;
    if (!rst && feat_rd_en) begin
      rexp_t r;
      r.at   = cyc + 2;
      r.data = feat_word(feat_addrb[FAW+1:2]);
      fq.push_back(r);
    end
    if (rst) begin
      m_mode = 0; m_err = '0; m_total = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        m_len[k] = 0; m_cnt[k] = 0; m_done[k] = 0; m_csum[k] = '0;
      end
    end else if (load_start) begin
      m_mode = 1; m_err = '0; m_total = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        m_len[k]  = int'(cfg_len[k*AW +: AW]);
        m_cnt[k]  = 0;
        m_done[k] = (m_len[k] == 0);
        m_csum[k] = '0;
      end
    end else if (load_clr) begin
      m_mode = 0; m_err = '0;
      for (int k = 0; k < NUM_CH; k++) m_done[k] = 0;
    end else begin
      all_pre = 1;
      for (int k = 0; k < NUM_CH; k++) if (!m_done[k]) all_pre = 0;
      if (m_mode == 1 && s_ena && s_wea) begin
        int ch, wa;
        bit mis, ok, ovf, rng;
        ch  = int'(s_ch);
        wa  = int'(s_addra) / 4;
        mis = (int'(s_addra) % 4) != 0;
        ok  = ch < NUM_CH;
        ovf = ok ? m_done[ch] : 1'b0;
        rng = !ok || (wa >= (ok ? m_len[ch] : 0));
        if (mis) m_err[0] = 1'b1;
        if (ovf) m_err[1] = 1'b1;
        if (rng) m_err[2] = 1'b1;
        if (!mis && !ovf && !rng) begin
          wexp_t w;
          acc = 1;
          m_cnt[ch]++;
          m_total++;
          m_csum[ch] = m_csum[ch] + s_din;
          if (m_cnt[ch] == m_len[ch]) m_done[ch] = 1;
          w.en   = NUM_CH'(1) << ch;
          w.addr = AW'(wa);
          w.din  = s_din[DW-1:0];
          wq.push_back(w);
        end
      end
      if (m_mode == 1 && all_pre) m_mode = 2;
    end
    @(posedge clk);
    @(negedge clk);
    check("wr_fire", 64'(ch_ena != '0), 64'(acc));
    check("ch_done", 64'(ch_done), 64'(m_done_vec()));
    check("err_flags", 64'(err_flags), 64'(m_err));
    check("all_done", 64'(all_done), 64'((m_mode == 2) && (&m_done_vec())));
`ifdef GAT_LOAD_CHECKSUM_EN
    check("dbg_csum", 64'(state_dbg[23:0]),
          64'((int'(s_ch) < NUM_CH) ? m_csum[int'(s_ch)][23:0] : 24'd0));
`else
    check("dbg_total", 64'(state_dbg[23:0]), 64'(24'(m_total)));
`endif
  endtask

  task automatic quiet();
    load_start = 0; load_clr = 0; s_ena = 0; s_wea = 0;
    feat_rd_en = 0;
  endtask

  task automatic idle(int n);
    quiet();
    repeat (n) step();
  endtask

  task automatic start(int a, int b, int c);
    quiet();
    cfg_len = {AW'(c), AW'(b), AW'(a)};
    load_start = 1;
    step();
    load_start = 0;
  endtask

  task automatic wr(int ch, int byte_addr, logic [31:0] data);
    quiet();
    s_ena = 1; s_wea = 1;
    s_ch = SW'(ch);
    s_addra = (AW+2)'(byte_addr);
    s_din = data;
    step();
    s_ena = 0; s_wea = 0;
  endtask

  // Monitor: pop and compare whenever the DUT presents a write or read.
  initial begin
    forever begin
      @(negedge clk);
      if (ch_ena !== '0) begin
        if (wq.size() == 0) begin
          check("wr_unexpected", 64'(ch_ena), 64'(0));
        end else begin
          wexp_t w;
          w = wq.pop_front();
          check("wr_ena", 64'(ch_ena), 64'(w.en));
          check("wr_wea", 64'(ch_wea), 64'(w.en));
          check("wr_addr", 64'(ch_addra), 64'(w.addr));
          check("wr_din", 64'(ch_din), 64'(w.din));
          $display("write en=%b addr=%0h din=%0h", ch_ena, ch_addra, ch_din);
        end
      end
      if (feat_valid === 1'b1) begin
        if (fq.size() == 0) begin
          check("rd_unexpected", 64'(feat_valid), 64'(0));
        end else begin
          rexp_t r;
          r = fq.pop_front();
          check("rd_cycle", 64'(cyc), 64'(r.at));
          check("rd_data", 64'(feat_dout), 64'(r.data));
          $display("read data=%h at cycle %0d", feat_dout, cyc);
        end
      end
    end
  end

  initial begin
    rst = 1; cfg_len = '0; s_ch = '0; s_addra = '0; s_din = '0;
    feat_addrb = '0;
    quiet();
    repeat (3) step();
    check("rst_addra", 64'(ch_addra), 64'(0));
    check("rst_din", 64'(ch_din), 64'(0));
    check("rst_dbg", 64'(state_dbg), 64'(0));
    check("rst_valid", 64'(feat_valid), 64'(0));
    rst = 0;
    idle(2);

    // Full load, lengths {4,2,3}
    start(4, 2, 3);
    for (int i = 0; i < 4; i++) wr(0, 4 * i, 32'h1000 + i);
    check("tp_done_a", 64'(ch_done), 64'(3'b001));
    for (int i = 0; i < 2; i++) wr(1, 4 * i, 32'h2000 + i);
    check("tp_done_b", 64'(ch_done), 64'(3'b011));
    for (int i = 0; i < 3; i++) wr(2, 4 * i, 32'hFFFF_3000 + i);
    check("tp_done_c", 64'(ch_done), 64'(3'b111));
    check("tp_all_early", 64'(all_done), 64'(0));
    idle(1);
    check("tp_all_late", 64'(all_done), 64'(1));
    wr(0, 0, 32'h55);  // ignored in READY
    check("tp_ready_err", 64'(err_flags), 64'(0));

    // Error cases
    start(4, 2, 3);
    wr(0, 'h6, 32'h77);
    check("tp_misalign", 64'(err_flags), 64'(3'b001));
    wr(1, 0, 32'h1); wr(1, 4, 32'h2); wr(1, 0, 32'h3);
    check("tp_overflow", 64'(err_flags[1]), 64'(1));
    check("tp_ovf_done", 64'(ch_done), 64'(3'b010));
    wr(0, 'h14, 32'h4); wr(3, 0, 32'h5);
    check("tp_range", 64'(err_flags), 64'(3'b111));

    // Back-to-back feature reads
    quiet();
    for (int i = 0; i < 3; i++) begin
      feat_rd_en = 1; feat_addrb = (FAW+2)'(4 * i);
      step();
    end
    idle(3);

    // Reset mid-load, then a clean second load
    start(4, 2, 3);
    wr(0, 0, 32'h9); wr(2, 0, 32'hA); wr(1, 1, 32'hB);
    rst = 1; step(); rst = 0;
    check("tp_rst_flags", 64'({err_flags, ch_done}), 64'(0));
    start(4, 2, 3);
    for (int i = 0; i < 4; i++) wr(0, 4 * i, $urandom());
    for (int i = 0; i < 2; i++) wr(1, 4 * i, $urandom());
    for (int i = 0; i < 3; i++) wr(2, 4 * i, $urandom());
    idle(1);
    check("tp_reload_all", 64'(all_done), 64'(1));

    // Randomized traffic
    for (int it = 0; it < 1500; it++) begin
      int r;
      int wa;
      r = $urandom_range(0, 99);
      load_start = (r < 2);
      load_clr   = (r == 2);
      if (load_start)
        cfg_len = {AW'($urandom_range(0, 5)), AW'($urandom_range(0, 5)),
                   AW'($urandom_range(0, 5))};
      s_ena = ($urandom_range(0, 9) != 0);
      s_wea = ($urandom_range(0, 7) != 0);
      s_ch  = SW'($urandom_range(0, 3));
      wa    = $urandom_range(0, 6);
      s_addra = (AW+2)'(wa * 4);
      if ($urandom_range(0, 15) == 0) s_addra[1:0] = 2'($urandom_range(1, 3));
      s_din = $urandom();
      feat_rd_en = 1'($urandom_range(0, 1));
      feat_addrb = (FAW+2)'($urandom());
      step();
    end

    idle(4);
    check("wq_empty", 64'(wq.size()), 64'(0));
    check("fq_empty", 64'(fq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
